// File: rtl/crc16_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the CRC-16/CCITT generator and checker:
//   CRC16_POLY          generator polynomial 0x1021 (MSB-first, no reflection)
//   CRC16_INIT_DEFAULT  default CRC register preset 0xFFFF
//   state_t             checker frame FSM states {IDLE, RECV, DONE}
//   crc16_byte()        one byte of CRC update, data bit 7 first
// -----------------------------------------------------------------------------
package crc16_pkg;

   localparam logic [15:0] CRC16_POLY         = 16'h1021;
   localparam logic [15:0] CRC16_INIT_DEFAULT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Eight serial shift/XOR steps unrolled into one combinational update.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  data);
      logic [15:0] crc;
      crc = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (crc[15] ^ data[i]) crc = {crc[14:0], 1'b0} ^ CRC16_POLY;
         else                   crc = {crc[14:0], 1'b0};
      end
      return crc;
   endfunction

endpackage

// File: rtl/crc16_checker_if.sv
// -----------------------------------------------------------------------------
// crc16_checker_if
// Framed byte stream feeding the CRC checker.
//   data_in[7:0]  frame byte
//   data_valid    data_in is valid this cycle
//   sof           first byte of a frame (qualified by data_valid)
//   eof           last byte of a frame, the CRC LSB (qualified by data_valid)
// Modports: master drives the stream (deserializer), slave consumes it.
// -----------------------------------------------------------------------------
interface crc16_checker_if;

   logic [7:0] data_in;
   logic       data_valid;
   logic       sof;
   logic       eof;

   modport master (output data_in, data_valid, sof, eof);
   modport slave  (input  data_in, data_valid, sof, eof);

endinterface

// File: rtl/crc16_byte_update.sv
// -----------------------------------------------------------------------------
// crc16_byte_update
// Combinational single-byte CRC-16/CCITT update, shared with the generator.
//   crc_in[15:0]   current CRC register
//   data[7:0]      byte to absorb, bit 7 first
//   crc_out[15:0]  updated CRC register
// -----------------------------------------------------------------------------
module crc16_byte_update
   import crc16_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   assign crc_out = crc16_byte(crc_in, data);

endmodule

// File: rtl/crc16_checker.sv
// -----------------------------------------------------------------------------
// crc16_checker
// Receive-side CRC-16/CCITT checker. Runs the CRC over payload plus the two
// trailing CRC bytes; a zero residue with a legal length passes the frame.
//   clk, rst        clock, asynchronous active-high reset
//   rx              framed byte stream (crc16_checker_if.slave)
//   busy            a frame is in progress
//   done            one-cycle pulse, result flags valid
//   crc_ok/crc_err  pass/fail of the last frame, held until the next sof
//   len_err         last frame length < 3 or > MAX_LEN
//   byte_count      bytes of current/last frame, saturating at MAX_LEN+1
//   crc_value       running CRC register
//   err_count       failed-frame counter (only with CRC16_CHK_ERR_CNT_EN)
// Build option: define CRC16_CHK_ERR_CNT_EN to add err_count.
// -----------------------------------------------------------------------------
module crc16_checker
   import crc16_pkg::*;
#(
   parameter logic [15:0] CRC_INIT = CRC16_INIT_DEFAULT,
   parameter int          MAX_LEN  = 1024,
   parameter int          LEN_W    = 11
) (
   input  logic              clk,
   input  logic              rst,
   crc16_checker_if.slave    rx,
   output logic              busy,
   output logic              done,
   output logic              crc_ok,
   output logic              crc_err,
   output logic              len_err,
   output logic [LEN_W-1:0]  byte_count,
   output logic [15:0]       crc_value
`ifdef CRC16_CHK_ERR_CNT_EN
   ,
   output logic [15:0]       err_count
`endif
);

   localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] CNT_MIN = LEN_W'(3);
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   state_t           state_q, state_d;
   logic [15:0]      crc_q, crc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic             lerr_q, lerr_d;

   logic             start;
   logic             take;
   logic             len_bad;
   logic [15:0]      upd_base;
   logic [15:0]      upd_crc;

   // sof restarts a frame from any state, so the update seed switches to
   // CRC_INIT on that byte instead of the running register.
   assign start    = rx.data_valid & rx.sof;
   assign upd_base = start ? CRC_INIT : crc_q;

   crc16_byte_update u_update (
      .crc_in  (upd_base),
      .data    (rx.data_in),
      .crc_out (upd_crc)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      ok_d    = ok_q;
      err_d   = err_q;
      lerr_d  = lerr_q;
      take    = 1'b0;
      len_bad = 1'b0;

      if (start) begin
         take   = 1'b1;
         crc_d  = upd_crc;
         cnt_d  = CNT_ONE;
         ok_d   = 1'b0;
         err_d  = 1'b0;
         lerr_d = 1'b0;
      end else if (rx.data_valid && (state_q == RECV)) begin
         take  = 1'b1;
         crc_d = upd_crc;
         cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CNT_ONE;
      end

      // Flags are evaluated on the eof byte from the post-update values so
      // they are registered alongside done in the DONE cycle.
      if (take && rx.eof) begin
         len_bad = (cnt_d < CNT_MIN) || (cnt_d > CNT_MAX);
         ok_d    = (crc_d == 16'h0000) && !len_bad;
         err_d   = !ok_d;
         lerr_d  = len_bad;
         state_d = DONE;
      end else if (take) begin
         state_d = RECV;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= CRC_INIT;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         lerr_q  <= lerr_d;
      end
   end

   assign busy       = (state_q == RECV);
   assign done       = (state_q == DONE);
   assign crc_ok     = ok_q;
   assign crc_err    = err_q;
   assign len_err    = lerr_q;
   assign byte_count = cnt_q;
   assign crc_value  = crc_q;

`ifdef CRC16_CHK_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (done && err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_checker.sv
// -----------------------------------------------------------------------------
// tb_crc16_checker
// Two checkers share one byte stream: dut_a with default parameters and
// dut_b with CRC_INIT=0, MAX_LEN=8 for cheap length-boundary frames. A
// frame-level model (byte queue + CRC over the whole queue) predicts all
// outputs of both every cycle; directed literals pin the model and key results.
// -----------------------------------------------------------------------------
module tb_crc16_checker;

   typedef logic [7:0] bq_t[$];

   localparam logic [15:0] INIT_A = 16'hFFFF;
   localparam logic [15:0] INIT_B = 16'h0000;
   localparam int          MAX_A  = 1024;
   localparam int          MAX_B  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   crc16_checker_if bus ();

   logic        a_busy, a_done, a_ok, a_err, a_lerr;
   logic [10:0] a_cnt;
   logic [15:0] a_crc;
   logic        b_busy, b_done, b_ok, b_err, b_lerr;
   logic [3:0]  b_cnt;
   logic [15:0] b_crc;
`ifdef CRC16_CHK_ERR_CNT_EN
   logic [15:0] a_ecnt, b_ecnt;
`endif

   crc16_checker #(.CRC_INIT(INIT_A), .MAX_LEN(MAX_A), .LEN_W(11)) dut_a (
      .clk(clk), .rst(rst), .rx(bus),
      .busy(a_busy), .done(a_done), .crc_ok(a_ok), .crc_err(a_err),
      .len_err(a_lerr), .byte_count(a_cnt), .crc_value(a_crc)
`ifdef CRC16_CHK_ERR_CNT_EN
      , .err_count(a_ecnt)
`endif
   );

   crc16_checker #(.CRC_INIT(INIT_B), .MAX_LEN(MAX_B), .LEN_W(4)) dut_b (
      .clk(clk), .rst(rst), .rx(bus),
      .busy(b_busy), .done(b_done), .crc_ok(b_ok), .crc_err(b_err),
      .len_err(b_lerr), .byte_count(b_cnt), .crc_value(b_crc)
`ifdef CRC16_CHK_ERR_CNT_EN
      , .err_count(b_ecnt)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit running = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // CRC of a whole message as polynomial long division, bit 7 of each byte first.
   function automatic logic [15:0] crc_of(input logic [15:0] init, input bq_t msg);
      logic [15:0] r;
      r = init;
      foreach (msg[k]) begin
         for (int b = 7; b >= 0; b--) begin
            logic fb;
            fb = r[15] ^ msg[k][b];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return r;
   endfunction

   // ---------------- frame-level model ----------------
   logic [15:0] m_init [2] = '{INIT_A, INIT_B};
   int          m_max  [2] = '{MAX_A, MAX_B};
   bq_t         m_q;
   bit          m_in_frame = 1'b0;
   bit          m_done     = 1'b0;
   bit          m_ok   [2] = '{1'b0, 1'b0};
   bit          m_err  [2] = '{1'b0, 1'b0};
   bit          m_lerr [2] = '{1'b0, 1'b0};
   int          m_ecnt [2] = '{0, 0};

   function automatic int exp_cnt(input int i);
      return (m_q.size() > m_max[i] + 1) ? m_max[i] + 1 : m_q.size();
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_q.delete();
            m_in_frame = 1'b0;
            m_done     = 1'b0;
            for (int i = 0; i < 2; i++) begin
               m_ok[i] = 1'b0; m_err[i] = 1'b0; m_lerr[i] = 1'b0; m_ecnt[i] = 0;
            end
         end else begin
            bit took;
            took = 1'b0;
            if (m_done)
               for (int i = 0; i < 2; i++)
                  if (m_err[i] && m_ecnt[i] < 16'hFFFF) m_ecnt[i]++;
            m_done = 1'b0;
            if (bus.data_valid && bus.sof) begin
               m_q.delete();
               m_q.push_back(bus.data_in);
               for (int i = 0; i < 2; i++) begin
                  m_ok[i] = 1'b0; m_err[i] = 1'b0; m_lerr[i] = 1'b0;
               end
               m_in_frame = 1'b1;
               took = 1'b1;
            end else if (bus.data_valid && m_in_frame) begin
               m_q.push_back(bus.data_in);
               took = 1'b1;
            end
            if (took && bus.eof) begin
               for (int i = 0; i < 2; i++) begin
                  int n;
                  n = exp_cnt(i);
                  m_lerr[i] = (n < 3) || (n > m_max[i]);
                  m_ok[i]   = (crc_of(m_init[i], m_q) == 16'h0000) && !m_lerr[i];
                  m_err[i]  = !m_ok[i];
               end
               m_in_frame = 1'b0;
               m_done     = 1'b1;
            end
         end
      end
   end

   task automatic check_dut(input int i, input logic busy, input logic done,
                            input logic ok, input logic err, input logic lerr,
                            input int cnt, input logic [15:0] crc, input logic [15:0] ecnt);
      check($sformatf("dut%0d.busy", i),       busy, m_in_frame);
      check($sformatf("dut%0d.done", i),       done, m_done);
      check($sformatf("dut%0d.crc_ok", i),     ok,   m_ok[i]);
      check($sformatf("dut%0d.crc_err", i),    err,  m_err[i]);
      check($sformatf("dut%0d.len_err", i),    lerr, m_lerr[i]);
      check($sformatf("dut%0d.byte_count", i), cnt,  exp_cnt(i));
      check($sformatf("dut%0d.crc_value", i),  crc,  crc_of(m_init[i], m_q));
`ifdef CRC16_CHK_ERR_CNT_EN
      check($sformatf("dut%0d.err_count", i),  ecnt, m_ecnt[i]);
`else
      if (ecnt != 16'h0000) check($sformatf("dut%0d.ecnt_arg", i), ecnt, 0);
`endif
   endtask

   // Compare process: outputs are registered, so the falling edge is stable.
   initial begin
      forever begin
         @(negedge clk);
         if (running) begin
`ifdef CRC16_CHK_ERR_CNT_EN
            check_dut(0, a_busy, a_done, a_ok, a_err, a_lerr, int'(a_cnt), a_crc, a_ecnt);
            check_dut(1, b_busy, b_done, b_ok, b_err, b_lerr, int'(b_cnt), b_crc, b_ecnt);
`else
            check_dut(0, a_busy, a_done, a_ok, a_err, a_lerr, int'(a_cnt), a_crc, 16'h0000);
            check_dut(1, b_busy, b_done, b_ok, b_err, b_lerr, int'(b_cnt), b_crc, 16'h0000);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d, input bit s, input bit e);
      @(negedge clk);
      bus.data_in    = d;
      bus.data_valid = 1'b1;
      bus.sof        = s;
      bus.eof        = e;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.sof        = 1'b0;
      bus.eof        = 1'b0;
      bus.data_in    = 8'h00;
   endtask

   task automatic send_frame(input bq_t f);
      foreach (f[k]) send(f[k], k == 0, k == f.size() - 1);
   endtask

   function automatic bq_t with_crc(input logic [15:0] init, input bq_t p);
      bq_t f;
      logic [15:0] c;
      f = p;
      c = crc_of(init, p);
      f.push_back(c[15:8]);
      f.push_back(c[7:0]);
      return f;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t digits, frame_a, frame_bad, p, f;
      logic [15:0] c;
      digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      frame_a   = digits; frame_a.push_back(8'h29);   frame_a.push_back(8'hB1);
      frame_bad = digits; frame_bad.push_back(8'h29); frame_bad.push_back(8'hB0);

      bus.data_in = 8'h00; bus.data_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;

      // Model pins: standard check value and zero residue over payload+CRC.
      check("model_check_value", crc_of(16'hFFFF, digits), 16'h29B1);
      check("model_residue",     crc_of(16'hFFFF, frame_a), 16'h0000);

      repeat (2) @(negedge clk);
      check("rst_crc_value",  a_crc,  16'hFFFF);
      check("rst_byte_count", a_cnt,  0);
      check("rst_busy",       a_busy, 0);
      check("rst_flags",      {a_done, a_ok, a_err, a_lerr}, 4'b0000);
      rst = 1'b0;

      // Stray byte without sof in IDLE is ignored.
      send(8'h77, 1'b0, 1'b0);
      idle();

      // Good frame "123456789" + 29 B1.
      send_frame(frame_a);
      idle();
      check("a_done",     a_done, 1);
      check("a_busy_done", a_busy, 0);
      check("a_crc_ok",   a_ok,   1);
      check("a_crc_err",  a_err,  0);
      check("a_count",    a_cnt,  11);
      check("a_crc_zero", a_crc,  16'h0000);
      idle();
      check("a_done_pulse_1cycle", a_done, 0);
      check("a_ok_held",  a_ok,   1);

      // Corrupted last byte.
      send_frame(frame_bad);
      idle();
      check("bad_ok",   a_ok,   0);
      check("bad_err",  a_err,  1);
      check("bad_len",  a_lerr, 0);

      // Generator-style frame: payload followed by its CRC, MSB first.
      p = '{8'h55, 8'hA1, 8'h12, 8'h34};
      send_frame(with_crc(16'hFFFF, p));
      idle();
      check("gen_ok",    a_ok,  1);
      check("gen_count", a_cnt, 6);

      // Single byte sof&eof.
      send(8'h55, 1'b1, 1'b1);
      idle();
      check("one_byte_len", a_lerr, 1);
      check("one_byte_err", a_err,  1);

      // Two zero bytes: zero residue on the CRC_INIT=0 instance but too short.
      send_frame('{8'h00, 8'h00});
      idle();
      check("two_byte_b_crc", b_crc,  16'h0000);
      check("two_byte_b_len", b_lerr, 1);
      check("two_byte_b_ok",  b_ok,   0);

      // Abort: new sof on the 6th byte restarts with a good frame.
      for (int k = 0; k < 5; k++) send(digits[k], k == 0, 1'b0);
      send_frame(frame_a);
      idle();
      check("abort_ok",    a_ok,  1);
      check("abort_count", a_cnt, 11);

      // Back-to-back frames: second sof lands in the DONE cycle.
      send_frame(frame_bad);
      send_frame(frame_a);
      idle();
      check("b2b_ok", a_ok, 1);

      // Asynchronous reset mid-frame.
      send(8'h31, 1'b1, 1'b0);
      send(8'h32, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy",  a_busy, 0);
      check("midrst_count", a_cnt,  0);
      check("midrst_crc",   a_crc,  16'hFFFF);
      check("midrst_flags", {a_done, a_ok, a_err, a_lerr}, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      bus.data_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
      send_frame(frame_a);
      idle();
      check("postrst_ok", a_ok, 1);

      // Length boundaries on the MAX_LEN=8 instance.
      p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_frame(with_crc(16'h0000, p));
      idle();
      check("max_len_b_ok",    b_ok,   1);
      check("max_len_b_count", b_cnt,  8);
      f = '{};
      for (int k = 0; k < 12; k++) f.push_back(8'(8'h10 + k));
      send_frame(f);
      idle();
      check("sat_b_count", b_cnt,  9);
      check("sat_b_len",   b_lerr, 1);

`ifdef CRC16_CHK_ERR_CNT_EN
      c = a_ecnt;
      repeat (3) begin
         send_frame(frame_bad);
         idle();
      end
      idle();
      check("err_count_plus3", a_ecnt, c + 16'd3);
`else
      c = 16'h0000;
`endif
      if (c != 16'h0000) idle();

      repeat (3) idle();
      running = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
